// File: rtl/dmi_pkg.sv
// Shared DMI types: op/resp encodings, DTM FSM states, bus payload structs,
// default widths and small decode helpers.
package dmi_pkg;

    localparam int unsigned ABITS_DEF = 7;
    localparam int unsigned DBITS_DEF = 32;
    localparam int unsigned OP_W      = 2;

    typedef enum logic [1:0] {
        DMI_NOP   = 2'd0,
        DMI_READ  = 2'd1,
        DMI_WRITE = 2'd2,
        DMI_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        DMI_OK   = 2'd0,
        DMI_FAIL = 2'd2,
        DMI_BUSY = 2'd3
    } dmi_resp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } dtm_state_e;

    typedef struct packed {
        logic [ABITS_DEF-1:0] addr;
        logic [DBITS_DEF-1:0] data;
        dmi_op_e              op;
    } dmi_req_t;

    typedef struct packed {
        logic [DBITS_DEF-1:0] data;
        dmi_resp_e            resp;
    } dmi_rsp_t;

    // Response code as stored in sticky status: the undefined code 1 reads back as failed.
    function automatic logic [1:0] resp_to_sticky(input logic [1:0] resp);
        return (resp == 2'd1) ? 2'(DMI_FAIL) : resp;
    endfunction

    // Only read and write produce a DMI request; nop and reserved do nothing.
    function automatic logic is_access_op(input logic [1:0] op);
        return (op == 2'(DMI_READ)) || (op == 2'(DMI_WRITE));
    endfunction

endpackage

// File: rtl/dtm_dmi_access_ctrl_if.sv
// DMI request/response channel between the DTM controller (master) and the
// DMI access chain (slave). Both channels use valid/ready.
//   req_valid/req_ready, req_addr, req_data, req_op : request channel
//   rsp_valid/rsp_ready, rsp_data, rsp_resp         : response channel
interface dtm_dmi_access_ctrl_if #(
    parameter int unsigned ABITS = 7,
    parameter int unsigned DBITS = 32
) ();
    logic             req_valid;
    logic             req_ready;
    logic [ABITS-1:0] req_addr;
    logic [DBITS-1:0] req_data;
    logic [1:0]       req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DBITS-1:0] rsp_data;
    logic [1:0]       rsp_resp;

    modport master (
        output req_valid, req_addr, req_data, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_resp
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_resp
    );
endinterface

// File: rtl/dtm_dmi_access_ctrl_sticky.sv
// Sticky DMI status and Capture-DR op generation.
//   i_busy          : controller is in REQ or RSP
//   i_upd_valid     : Update-DR pulse (busy violation when i_busy)
//   i_cap_valid     : Capture-DR pulse (busy violation when i_busy)
//   i_dmireset      : clear sticky
//   i_dmihardreset  : clear sticky
//   i_rsp_fire      : accepted, non-discarded DMI response
//   i_rsp_resp      : response code of that response
//   o_cap_op        : status presented on Capture-DR
module dmi_sticky_status
    import dmi_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_busy,
    input  logic       i_upd_valid,
    input  logic       i_cap_valid,
    input  logic       i_dmireset,
    input  logic       i_dmihardreset,
    input  logic       i_rsp_fire,
    input  logic [1:0] i_rsp_resp,
    output logic [1:0] o_cap_op
);
    logic [1:0] r_sticky;
    logic       w_busy_evt;
    logic       w_clear;

    assign w_busy_evt = i_busy & (i_upd_valid | i_cap_valid);
    assign w_clear    = i_dmireset | i_dmihardreset;

    // A busy violation beats a same-cycle clear; a response only records into a clean status.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sticky <= 2'(DMI_OK);
        end else if (w_busy_evt && ((r_sticky == 2'(DMI_OK)) || w_clear)) begin
            r_sticky <= 2'(DMI_BUSY);
        end else if (w_clear) begin
            r_sticky <= 2'(DMI_OK);
        end else if (i_rsp_fire && (r_sticky == 2'(DMI_OK)) && (i_rsp_resp != 2'(DMI_OK))) begin
            r_sticky <= resp_to_sticky(i_rsp_resp);
        end
    end

    // Reading while an access is in flight reports busy even before it goes sticky.
    assign o_cap_op = (r_sticky != 2'(DMI_OK)) ? r_sticky
                    : (i_busy ? 2'(DMI_BUSY) : 2'(DMI_OK));
endmodule

// File: rtl/dtm_dmi_access_ctrl.sv
// JTAG DTM controller for the DMI access register: issues one DMI request per
// accepted Update-DR and collects the response for the next Capture-DR.
//   clock, reset             : clock and synchronous active-high reset
//   upd_valid/addr/data/op   : Update-DR of the DMI register
//   cap_valid                : Capture-DR of the DMI register
//   cap_addr/data/op         : value presented on Capture-DR
//   dmireset, dmihardreset   : dtmcs reset pulses
//   busy                     : an access is in flight
//   dmi                      : DMI request/response channel (master side)
module dtm_dmi_access_ctrl
    import dmi_pkg::*;
#(
    parameter int unsigned ABITS = ABITS_DEF,
    parameter int unsigned DBITS = DBITS_DEF,
    parameter int unsigned OP_W  = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   upd_valid,
    input  logic [ABITS-1:0]       upd_addr,
    input  logic [DBITS-1:0]       upd_data,
    input  logic [OP_W-1:0]        upd_op,
    input  logic                   cap_valid,
    output logic [ABITS-1:0]       cap_addr,
    output logic [DBITS-1:0]       cap_data,
    output logic [OP_W-1:0]        cap_op,
    input  logic                   dmireset,
    input  logic                   dmihardreset,
    output logic                   busy,
    dtm_dmi_access_ctrl_if.master  dmi
);
    dtm_state_e       r_state;
    logic             r_abort;
    logic             r_req_valid;
    logic             r_rsp_ready;
    logic [ABITS-1:0] r_req_addr;
    logic [DBITS-1:0] r_req_data;
    logic [1:0]       r_req_op;
    logic [ABITS-1:0] r_cap_addr;
    logic [DBITS-1:0] r_cap_data;
    logic [1:0]       w_cap_op;
    logic             w_busy;
    logic             w_rsp_hs;
    logic             w_discard;
    logic             w_accept;

    assign w_busy    = (r_state != ST_IDLE);
    assign w_rsp_hs  = (r_state == ST_RSP) & dmi.rsp_valid & r_rsp_ready;
    // A hardreset landing on the response cycle itself also abandons that response.
    assign w_discard = r_abort | dmihardreset;
    assign w_accept  = upd_valid & (w_cap_op == 2'(DMI_OK)) & is_access_op(2'(upd_op));

    // Request/response sequencing; all channel outputs are registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_abort     <= 1'b0;
            r_req_valid <= 1'b0;
            r_rsp_ready <= 1'b0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
            r_req_op    <= 2'(DMI_NOP);
            r_cap_addr  <= '0;
            r_cap_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // In IDLE cap_op equals the sticky value, so it gates acceptance.
                    if (w_accept) begin
                        r_req_addr  <= upd_addr;
                        r_req_data  <= upd_data;
                        r_req_op    <= 2'(upd_op);
                        r_cap_addr  <= upd_addr;
                        r_req_valid <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dmihardreset) begin
                        r_abort <= 1'b1;
                    end
                    if (r_req_valid && dmi.req_ready) begin
                        r_req_valid <= 1'b0;
                        r_rsp_ready <= 1'b1;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (w_rsp_hs) begin
                        r_rsp_ready <= 1'b0;
                        r_abort     <= 1'b0;
                        r_state     <= ST_IDLE;
                        if (!w_discard) begin
                            r_cap_data <= dmi.rsp_data;
                        end
                    end else if (dmihardreset) begin
                        r_abort <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    dmi_sticky_status u_sticky (
        .clock          (clock),
        .reset          (reset),
        .i_busy         (w_busy),
        .i_upd_valid    (upd_valid),
        .i_cap_valid    (cap_valid),
        .i_dmireset     (dmireset),
        .i_dmihardreset (dmihardreset),
        .i_rsp_fire     (w_rsp_hs & ~w_discard),
        .i_rsp_resp     (dmi.rsp_resp),
        .o_cap_op       (w_cap_op)
    );

    assign dmi.req_valid = r_req_valid;
    assign dmi.req_addr  = r_req_addr;
    assign dmi.req_data  = r_req_data;
    assign dmi.req_op    = r_req_op;
    assign dmi.rsp_ready = r_rsp_ready;
    assign cap_addr      = r_cap_addr;
    assign cap_data      = r_cap_data;
    assign cap_op        = OP_W'(w_cap_op);
    assign busy          = w_busy;
endmodule
